// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared types and constants for the UART transmit arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

  localparam int ERR_KBD_OVF = 0;
  localparam int ERR_AUX_OVF = 1;
  localparam int ERR_LOCK_TO = 2;

  localparam logic SRC_KBD = 1'b0;
  localparam logic SRC_AUX = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous FIFO with full/empty/count; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push;
  logic             pop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign pop       = rd_en_i && !empty_o;
  assign push      = wr_en_i && (!full_o || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter between the
// keyboard byte stream and an aux message source, keeping aux messages contiguous.
module uart_tx_arbiter #(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] kbdData,
  input  logic       kbdDataValid,
  input  logic [7:0] auxData,
  input  logic       auxDataValid,
  input  logic       auxLast,
  output logic       auxReady,
  output logic [7:0] txData,
  output logic       txDataValid,
  input  logic       txBusy,
  output logic [2:0] arbError
);
  import uart_tx_arb_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e    state_q, state_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          last_grant_q, last_grant_d;
  logic          lock_q, lock_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [BW-1:0] busy_cnt_q, busy_cnt_d;
  logic [2:0]    err_q, err_d;

  logic          kbd_pop, aux_pop;
  logic          grant_kbd, grant_aux;
  logic          lock_expire;
  logic [7:0]    kbd_rd;
  logic [8:0]    aux_rd;
  logic          kbd_full, kbd_empty, aux_full, aux_empty;
  logic [CW-1:0] kbd_count_unused, aux_count;
  logic          kbd_ovf, aux_ovf;

  byte_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_kbd_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (kbdDataValid),
    .wr_data_i (kbdData),
    .rd_en_i   (kbd_pop),
    .rd_data_o (kbd_rd),
    .full_o    (kbd_full),
    .empty_o   (kbd_empty),
    .count_o   (kbd_count_unused)
  );

  byte_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_aux_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (auxDataValid),
    .wr_data_i ({auxLast, auxData}),
    .rd_en_i   (aux_pop),
    .rd_data_o (aux_rd),
    .full_o    (aux_full),
    .empty_o   (aux_empty),
    .count_o   (aux_count)
  );

  assign kbd_ovf     = kbdDataValid && kbd_full && !kbd_pop;
  assign aux_ovf     = auxDataValid && aux_full && !aux_pop;
  assign auxReady    = (aux_count < CW'(DEPTH));
  assign txData      = tx_data_q;
  assign txDataValid = (state_q == SEND);
  assign arbError    = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      last_grant_q <= SRC_AUX;
      lock_q       <= 1'b0;
      lock_cnt_q   <= '0;
      busy_cnt_q   <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
      lock_cnt_q   <= lock_cnt_d;
      busy_cnt_q   <= busy_cnt_d;
      err_q        <= err_d;
    end
  end

  // Grant selection: a held lock reserves the transmitter for the aux message.
  always_comb begin
    grant_kbd = 1'b0;
    grant_aux = 1'b0;
    if (state_q == IDLE && !txBusy) begin
      if (lock_q) begin
        grant_aux = !aux_empty;
      end else if (!kbd_empty && !aux_empty) begin
        grant_aux = (last_grant_q == SRC_KBD);
        grant_kbd = (last_grant_q == SRC_AUX);
      end else begin
        grant_kbd = !kbd_empty;
        grant_aux = !aux_empty;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    last_grant_d = last_grant_q;
    lock_d       = lock_q;
    lock_cnt_d   = lock_cnt_q;
    busy_cnt_d   = busy_cnt_q;
    kbd_pop      = 1'b0;
    aux_pop      = 1'b0;
    lock_expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_kbd) begin
          kbd_pop      = 1'b1;
          tx_data_d    = kbd_rd;
          last_grant_d = SRC_KBD;
          state_d      = SEND;
        end else if (grant_aux) begin
          aux_pop      = 1'b1;
          tx_data_d    = aux_rd[7:0];
          lock_d       = !aux_rd[8];
          lock_cnt_d   = '0;
          last_grant_d = SRC_AUX;
          state_d      = SEND;
        end else if (lock_q && aux_empty) begin
          if (lock_cnt_q == LW'(LOCK_TIMEOUT - 1)) begin
            lock_d      = 1'b0;
            lock_cnt_d  = '0;
            lock_expire = 1'b1;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
      end
      SEND: begin
        busy_cnt_d = '0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A UART that never raises busy is assumed to have taken the byte.
        if (txBusy) begin
          state_d = WAIT_DONE;
        end else if (busy_cnt_q == BW'(BUSY_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!txBusy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (kbd_ovf)     err_d[ERR_KBD_OVF] = 1'b1;
    if (aux_ovf)     err_d[ERR_AUX_OVF] = 1'b1;
    if (lock_expire) err_d[ERR_LOCK_TO] = 1'b1;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between two byte sources:
- the PS/2 keyboard ASCII stream (kbd port);
- an auxiliary source (aux port), such as terminal status/cursor-report replies generated by the VGA/ANSI side.

Each source is buffered in a small FIFO. Grants are round-robin. Multi-byte aux messages are never interleaved with keyboard bytes. The block sits between kbd/ansi logic and uart, driving dataInTx/dataInTxValid and observing dataInTxBusy.

Parameters:
- DEPTH, 4, entries per source FIFO (power of 2, >=2).
- BUSY_TIMEOUT, 4, cycles to wait for txBusy to rise after a send pulse.
- LOCK_TIMEOUT, 65535, cycles a locked aux message may stall before forced unlock.

Ports:
- clk  in  1  system clock (24 MHz).
- reset  in  1  synchronous, active-high reset.
- kbdData  in  8  keyboard ASCII byte.
- kbdDataValid  in  1  one-cycle write strobe for kbdData.
- auxData  in  8  aux byte.
- auxDataValid  in  1  one-cycle write strobe for auxData.
- auxLast  in  1  qualifies auxData: final byte of an aux message.
- auxReady  out  1  aux FIFO not full.
- txData  out  8  byte to UART.
- txDataValid  out  1  one-cycle send pulse to UART.
- txBusy  in  1  UART transmitter busy.
- arbError  out  3  sticky errors: [0] kbd overflow, [1] aux overflow, [2] lock timeout.

Behaviour:
Reset:
- Synchronous, active-high, asserted on a clk edge.
- Outputs after reset: txData=0, txDataValid=0, arbError=0, auxReady=1.
- FIFOs emptied, FSM=IDLE, lock=0, last-grant=aux (so kbd wins the first tie).
- Reset mid-transfer drops every queued byte. A UART frame already started completes on its own.

FIFOs:
- Write when valid and (not full, or a pop occurs in the same cycle).
- Write while full with no pop: byte dropped, matching arbError bit set (sticky until reset).
- Aux FIFO stores 9 bits {auxLast, auxData}.

FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - if lock=1: grant aux only when the aux FIFO is non-empty; kbd is held off.
  - else, both non-empty: grant the source not granted last (round-robin).
  - else, one non-empty: grant that source.
  - on grant: pop the FIFO, register txData, go to SEND.
- SEND: txDataValid=1 for exactly this cycle. Go to WAIT_BUSY.
- WAIT_BUSY:
  - txBusy=1 -> WAIT_DONE.
  - BUSY_TIMEOUT cycles elapse without txBusy -> treat the byte as accepted, go to IDLE.
- WAIT_DONE: txBusy=0 -> IDLE.

Latency:
- Byte written at cycle N into an empty FIFO with the FSM idle: grant at N+1, txDataValid high at N+2.
- Back-to-back bytes: at least one IDLE cycle between WAIT_DONE exit and the next SEND.

Lock:
- Aux pop with last=0 sets lock. Aux pop with last=1 clears lock.
- While lock=1 and in IDLE with the aux FIFO empty, a counter runs. At LOCK_TIMEOUT it clears lock and sets arbError[2].
- The counter clears on any aux grant.

Simultaneous events:
- Write and pop on the same FIFO in one cycle: count unchanged.
- Kbd and aux writes in the same cycle: both accepted independently.
- txBusy already high in IDLE: no grant until it drops. Never issue SEND while txBusy=1.

auxReady is combinational from the aux FIFO count (count<DEPTH).

Decomposition:
- Package uart_tx_arb_pkg holds:
  - state enum {IDLE, SEND, WAIT_BUSY, WAIT_DONE};
  - error bit indices ERR_KBD_OVF=0, ERR_AUX_OVF=1, ERR_LOCK_TO=2;
  - source encoding SRC_KBD=0, SRC_AUX=1.
- One sub-module, byte_fifo, parameterised on WIDTH/DEPTH: sync FIFO with full, empty, count and same-cycle push/pop. Instantiated twice (WIDTH 8 and 9).

Test Plan:
- Single kbd write 0x41 at cycle 10, txBusy model asserts 1 cycle after the pulse and holds 20 cycles -> txDataValid only at cycle 12 with txData=0x41. Next grant no earlier than the cycle after txBusy falls.
- Kbd 0x61,0x62 and aux 0x1B,0x5B (last=0) written together, no lock in effect -> order 0x61, 0x1B, then aux stays locked: 0x5B before 0x62.
- Aux message 0x1B,0x5B,0x36,0x52 (last on 0x52) interleaved with kbd writes 0x30..0x33 -> all four aux bytes consecutive on txData; kbd bytes follow in order, none lost.
- Five kbd writes with txBusy held high, DEPTH=4 -> fifth dropped, arbError=3'b001. After release exactly four bytes sent; arbError stays set until reset.
- Aux byte 0x1B with last=0, then no further aux data, LOCK_TIMEOUT=16 -> after 16 idle cycles arbError[2]=1 and a pending kbd byte 0x7A is then sent.
- Reset asserted while 3 bytes queued and in WAIT_DONE -> next cycle txDataValid=0, arbError=0, auxReady=1, no further pulses. txBusy never rising after SEND -> FSM returns to IDLE after BUSY_TIMEOUT=4 cycles.
